// File: rtl/pid_aes_pkg.sv
// Shared definitions for the PID-to-AES packing path (pack and unpack sides).
package pid_aes_pkg;

  localparam int unsigned CTRL_WORD_W    = 16;
  localparam int unsigned CTRL_NUM_WORDS = 8;
  localparam int unsigned CTRL_IDX_W     = 3;
  localparam int unsigned AES_BLOCK_W    = CTRL_WORD_W * CTRL_NUM_WORDS;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } unpack_state_e;

  // Word k of a block, MSB-first: word 0 is the top slice, word 7 the bottom.
  function automatic logic [CTRL_WORD_W-1:0] word_slice(
    input logic [AES_BLOCK_W-1:0] blk,
    input logic [CTRL_IDX_W-1:0]  idx
  );
    int unsigned lsb;
    lsb = (CTRL_NUM_WORDS - 1 - 32'(idx)) * CTRL_WORD_W;
    return blk[lsb +: CTRL_WORD_W];
  endfunction

endpackage

// File: rtl/control_block_unpacker.sv
// Splits one decrypted 128-bit block into eight 16-bit control words, streams
// them out on valid/ready and then commits the whole set atomically.
module control_block_unpacker
  import pid_aes_pkg::*;
#(
  parameter int unsigned WORD_W    = CTRL_WORD_W,
  parameter int unsigned NUM_WORDS = CTRL_NUM_WORDS,
  parameter int unsigned IDX_W     = CTRL_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          blk_valid,
  output logic                          blk_ready,
  input  logic [WORD_W*NUM_WORDS-1:0]   blk_data,
  input  logic                          flush,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [WORD_W-1:0]             word_data,
  output logic [IDX_W-1:0]              word_idx,
  output logic                          word_last,
  output logic [WORD_W-1:0]             control_signal_0,
  output logic [WORD_W-1:0]             control_signal_1,
  output logic [WORD_W-1:0]             control_signal_2,
  output logic [WORD_W-1:0]             control_signal_3,
  output logic [WORD_W-1:0]             control_signal_4,
  output logic [WORD_W-1:0]             control_signal_5,
  output logic [WORD_W-1:0]             control_signal_6,
  output logic [WORD_W-1:0]             control_signal_7,
  output logic                          ctrl_update
);

  localparam int unsigned      BLOCK_W  = WORD_W * NUM_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  unpack_state_e        state_q, state_d;
  logic [BLOCK_W-1:0]   buf_q, buf_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 commit_c;

  logic                 blk_ready_q, blk_ready_d;
  logic                 word_valid_q, word_valid_d;
  logic [WORD_W-1:0]    word_data_q, word_data_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  logic                 word_last_q, word_last_d;
  logic                 ctrl_update_q, ctrl_update_d;
  logic [WORD_W-1:0]    ctrl_q [NUM_WORDS];
  logic [WORD_W-1:0]    ctrl_d [NUM_WORDS];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, buffer/index update and commit decision; flush beats everything.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && blk_valid) begin
          buf_d   = blk_data;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (flush) begin
          buf_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (word_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            commit_c = 1'b1;
            state_d  = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Registered-output values for the next cycle, derived from next-state data only.
  always_comb begin
    blk_ready_d   = (state_d == IDLE);
    word_valid_d  = (state_d == STREAM);
    word_idx_d    = '0;
    word_data_d   = '0;
    word_last_d   = 1'b0;
    ctrl_update_d = commit_c;
    ctrl_d        = ctrl_q;
    if (state_d == STREAM) begin
      word_idx_d  = idx_d;
      word_data_d = word_slice(buf_d, idx_d);
      word_last_d = (idx_d == LAST_IDX);
    end
    if (commit_c) begin
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        ctrl_d[k] = word_slice(buf_q, IDX_W'(k));
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q         <= '0;
      idx_q         <= '0;
      blk_ready_q   <= 1'b1;
      word_valid_q  <= 1'b0;
      word_data_q   <= '0;
      word_idx_q    <= '0;
      word_last_q   <= 1'b0;
      ctrl_update_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        ctrl_q[k] <= '0;
      end
    end else begin
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      blk_ready_q   <= blk_ready_d;
      word_valid_q  <= word_valid_d;
      word_data_q   <= word_data_d;
      word_idx_q    <= word_idx_d;
      word_last_q   <= word_last_d;
      ctrl_update_q <= ctrl_update_d;
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        ctrl_q[k] <= ctrl_d[k];
      end
    end
  end

  assign blk_ready        = blk_ready_q;
  assign word_valid       = word_valid_q;
  assign word_data        = word_data_q;
  assign word_idx         = word_idx_q;
  assign word_last        = word_last_q;
  assign ctrl_update      = ctrl_update_q;
  assign control_signal_0 = ctrl_q[0];
  assign control_signal_1 = ctrl_q[1];
  assign control_signal_2 = ctrl_q[2];
  assign control_signal_3 = ctrl_q[3];
  assign control_signal_4 = ctrl_q[4];
  assign control_signal_5 = ctrl_q[5];
  assign control_signal_6 = ctrl_q[6];
  assign control_signal_7 = ctrl_q[7];

endmodule

// File: tb/tb_control_block_unpacker.sv
// Self-checking bench for control_block_unpacker with a block-level reference model.
module tb_control_block_unpacker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         flush;
  logic         word_valid;
  logic         word_ready;
  logic [15:0]  word_data;
  logic [2:0]   word_idx;
  logic         word_last;
  logic [15:0]  cs0, cs1, cs2, cs3, cs4, cs5, cs6, cs7;
  logic         ctrl_update;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_ctrl [8];

  control_block_unpacker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .blk_valid        (blk_valid),
    .blk_ready        (blk_ready),
    .blk_data         (blk_data),
    .flush            (flush),
    .word_valid       (word_valid),
    .word_ready       (word_ready),
    .word_data        (word_data),
    .word_idx         (word_idx),
    .word_last        (word_last),
    .control_signal_0 (cs0),
    .control_signal_1 (cs1),
    .control_signal_2 (cs2),
    .control_signal_3 (cs3),
    .control_signal_4 (cs4),
    .control_signal_5 (cs5),
    .control_signal_6 (cs6),
    .control_signal_7 (cs7),
    .ctrl_update      (ctrl_update)
  );

  always #5 clk = ~clk;

  // Reference: word k is the k-th 16-bit field counting from the top of the block.
  function automatic logic [15:0] mword(input logic [127:0] b, input int k);
    return 16'(b >> (16 * (7 - k)));
  endfunction

  function automatic logic [15:0] obs_ctrl(input int k);
    case (k)
      0: return cs0;
      1: return cs1;
      2: return cs2;
      3: return cs3;
      4: return cs4;
      5: return cs5;
      6: return cs6;
      default: return cs7;
    endcase
  endfunction

  function automatic int ctrl_diffs();
    int n = 0;
    for (int k = 0; k < 8; k++) if (obs_ctrl(k) !== exp_ctrl[k]) n++;
    return n;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one block, streams it with the chosen readiness pattern and checks the commit.
  task automatic run_block(input logic [127:0] b, input int stall_at, input int stall_len,
                           input bit rnd, output int lat);
    int k = 0;
    int stalled = 0;
    logic rdy;
    lat = 0;
    total++;
    if (blk_ready !== 1'b1) begin bad++; $display("FAIL blk_ready_before_block got %b want 1", blk_ready); end
    blk_valid = 1'b1; blk_data = b;
    step();
    blk_valid = 1'b0;
    while (k < 8 && lat < 200) begin
      total++;
      if (word_valid !== 1'b1 || word_idx !== 3'(k) || word_data !== mword(b, k) ||
          word_last !== (k == 7) || blk_ready !== 1'b0 || ctrl_update !== 1'b0) begin
        bad++;
        $display("FAIL stream_word got v=%b idx=%0d d=%h last=%b rdy=%b upd=%b want v=1 idx=%0d d=%h last=%b rdy=0 upd=0",
                 word_valid, word_idx, word_data, word_last, blk_ready, ctrl_update, k, mword(b, k), (k == 7));
      end
      total++;
      if (ctrl_diffs() != 0) begin bad++; $display("FAIL ctrl_stable_midstream got %0d differing words want 0", ctrl_diffs()); end
      if (k == stall_at && stalled < stall_len) begin rdy = 1'b0; stalled++; end
      else if (rnd) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      word_ready = rdy;
      step();
      if (rdy) k++;
      lat++;
    end
    word_ready = 1'b0;
    total++;
    if (k != 8) begin bad++; $display("FAIL stream_timeout got %0d words want 8", k); end
    for (int j = 0; j < 8; j++) exp_ctrl[j] = mword(b, j);
    total++;
    if (ctrl_update !== 1'b1 || blk_ready !== 1'b1 || word_valid !== 1'b0) begin
      bad++;
      $display("FAIL commit_cycle got upd=%b rdy=%b v=%b want upd=1 rdy=1 v=0", ctrl_update, blk_ready, word_valid);
    end
    total++;
    if (ctrl_diffs() != 0) begin
      bad++;
      $display("FAIL commit_values got cs0=%h cs7=%h want cs0=%h cs7=%h", cs0, cs7, exp_ctrl[0], exp_ctrl[7]);
    end
    step();
    total++;
    if (ctrl_update !== 1'b0) begin bad++; $display("FAIL update_pulse_width got %b want 0", ctrl_update); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; flush = 1'b0; word_ready = 1'b0;
    for (int k = 0; k < 8; k++) exp_ctrl[k] = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    total++;
    if (blk_ready !== 1'b1 || word_valid !== 1'b0 || word_data !== 16'h0 || word_idx !== 3'd0 ||
        word_last !== 1'b0 || ctrl_update !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h idx=%0d last=%b upd=%b want 1 0 0 0 0 0",
               blk_ready, word_valid, word_data, word_idx, word_last, ctrl_update);
    end
    total++;
    if (ctrl_diffs() != 0) begin bad++; $display("FAIL reset_ctrl got %0d nonzero words want 0", ctrl_diffs()); end
  endtask

  task automatic test_single_block();
    int lat;
    run_block(128'h0001_0002_0003_0004_0005_0006_0007_0008, -1, 0, 1'b0, lat);
    total++;
    if (lat != 8) begin bad++; $display("FAIL single_latency got %0d want 8", lat); end
  endtask

  task automatic test_backpressure();
    int lat;
    run_block(128'h0001_0002_0003_0004_0005_0006_0007_0008, 2, 3, 1'b0, lat);
    total++;
    if (lat != 11) begin bad++; $display("FAIL backpressure_latency got %0d want 11", lat); end
  endtask

  task automatic test_flush();
    logic [127:0] b;
    b = '1;
    word_ready = 1'b1; blk_valid = 1'b1; blk_data = b;
    step();
    blk_valid = 1'b0;
    repeat (4) step();
    total++;
    if (word_idx !== 3'd4 || word_data !== 16'hFFFF) begin
      bad++; $display("FAIL flush_setup got idx=%0d d=%h want idx=4 d=ffff", word_idx, word_data);
    end
    flush = 1'b1; word_ready = 1'b0;
    step();
    flush = 1'b0;
    total++;
    if (word_valid !== 1'b0 || blk_ready !== 1'b1 || ctrl_update !== 1'b0) begin
      bad++; $display("FAIL flush_midstream got v=%b rdy=%b upd=%b want 0 1 0", word_valid, blk_ready, ctrl_update);
    end
    step();
    total++;
    if (ctrl_update !== 1'b0 || ctrl_diffs() != 0) begin
      bad++; $display("FAIL flush_no_commit got upd=%b cs0=%h want upd=0 cs0=%h", ctrl_update, cs0, exp_ctrl[0]);
    end
    // flush while idle must block acceptance
    flush = 1'b1; blk_valid = 1'b1; blk_data = rand_block();
    step();
    flush = 1'b0; blk_valid = 1'b0;
    total++;
    if (word_valid !== 1'b0 || blk_ready !== 1'b1) begin
      bad++; $display("FAIL flush_idle_priority got v=%b rdy=%b want v=0 rdy=1", word_valid, blk_ready);
    end
    // flush on the last-word handshake: no commit
    b = rand_block();
    blk_valid = 1'b1; blk_data = b; word_ready = 1'b1;
    step();
    blk_valid = 1'b0;
    repeat (7) step();
    total++;
    if (word_idx !== 3'd7 || word_last !== 1'b1 || word_data !== mword(b, 7)) begin
      bad++; $display("FAIL flush_last_setup got idx=%0d last=%b d=%h want 7 1 %h", word_idx, word_last, word_data, mword(b, 7));
    end
    flush = 1'b1;
    step();
    flush = 1'b0; word_ready = 1'b0;
    total++;
    if (word_valid !== 1'b0 || ctrl_update !== 1'b0 || ctrl_diffs() != 0) begin
      bad++; $display("FAIL flush_last_no_commit got v=%b upd=%b diffs=%0d want 0 0 0", word_valid, ctrl_update, ctrl_diffs());
    end
    step();
    total++;
    if (ctrl_update !== 1'b0) begin bad++; $display("FAIL flush_last_late_update got %b want 0", ctrl_update); end
  endtask

  task automatic test_async_reset();
    logic [127:0] b;
    int lat;
    b = rand_block();
    word_ready = 1'b1; blk_valid = 1'b1; blk_data = b;
    step();
    blk_valid = 1'b0;
    repeat (3) step();
    total++;
    if (word_idx !== 3'd3 || word_data !== mword(b, 3)) begin
      bad++; $display("FAIL areset_setup got idx=%0d d=%h want 3 %h", word_idx, word_data, mword(b, 3));
    end
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) exp_ctrl[k] = '0;
    total++;
    if (word_valid !== 1'b0 || word_data !== 16'h0 || word_idx !== 3'd0 || word_last !== 1'b0 ||
        ctrl_update !== 1'b0 || ctrl_diffs() != 0) begin
      bad++; $display("FAIL areset_immediate got v=%b d=%h idx=%0d last=%b upd=%b diffs=%0d want all 0",
                      word_valid, word_data, word_idx, word_last, ctrl_update, ctrl_diffs());
    end
    word_ready = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    total++;
    if (blk_ready !== 1'b1 || ctrl_update !== 1'b0 || word_valid !== 1'b0) begin
      bad++; $display("FAIL areset_release got rdy=%b upd=%b v=%b want 1 0 0", blk_ready, ctrl_update, word_valid);
    end
    run_block(rand_block(), -1, 0, 1'b0, lat);
    total++;
    if (lat != 8) begin bad++; $display("FAIL areset_next_latency got %0d want 8", lat); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    a = 128'hA000_A001_A002_A003_A004_A005_A006_A007;
    b = 128'hB000_B001_B002_B003_B004_B005_B006_B007;
    blk_valid = 1'b1; blk_data = a; word_ready = 1'b1;
    step();
    blk_data = b;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (word_valid !== 1'b1 || word_data !== mword(a, k) || word_idx !== 3'(k)) begin
        bad++; $display("FAIL b2b_stream_a got v=%b d=%h idx=%0d want 1 %h %0d", word_valid, word_data, word_idx, mword(a, k), k);
      end
      step();
    end
    for (int j = 0; j < 8; j++) exp_ctrl[j] = mword(a, j);
    total++;
    if (ctrl_update !== 1'b1 || blk_ready !== 1'b1 || ctrl_diffs() != 0) begin
      bad++; $display("FAIL b2b_commit_a got upd=%b rdy=%b cs0=%h want 1 1 a000", ctrl_update, blk_ready, cs0);
    end
    step();
    blk_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (word_valid !== 1'b1 || word_data !== mword(b, k) || word_idx !== 3'(k) ||
          ctrl_update !== 1'b0 || ctrl_diffs() != 0) begin
        bad++; $display("FAIL b2b_stream_b got v=%b d=%h idx=%0d upd=%b cs0=%h want 1 %h %0d 0 a000",
                        word_valid, word_data, word_idx, ctrl_update, cs0, mword(b, k), k);
      end
      step();
    end
    word_ready = 1'b0;
    for (int j = 0; j < 8; j++) exp_ctrl[j] = mword(b, j);
    total++;
    if (ctrl_update !== 1'b1 || ctrl_diffs() != 0) begin
      bad++; $display("FAIL b2b_commit_b got upd=%b cs7=%h want 1 b007", ctrl_update, cs7);
    end
    step();
  endtask

  task automatic test_random();
    int lat;
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) step();
      run_block(rand_block(), -1, 0, 1'b1, lat);
      total++;
      if (lat < 8) begin bad++; $display("FAIL random_latency got %0d want >=8", lat); end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
